// File: rtl/fproc_requester.sv
// Core-side initiator for the fproc request/response handshake: issues one id, waits for the responder, returns the data.
// Optional WAIT-state abort is enabled by defining FPROC_REQ_TIMEOUT_EN.
module fproc_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [FPROC_ID_WIDTH-1:0] req_id,
  output logic                      req_ready,
  output logic [FPROC_ID_WIDTH-1:0] fproc_id,
  output logic                      fproc_enable,
  input  logic [DATA_WIDTH-1:0]     fproc_data,
  input  logic                      fproc_ready,
  output logic [DATA_WIDTH-1:0]     result_data,
  output logic                      result_valid,
  output logic                      result_timeout,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                    state_r;
  logic                      req_ready_r;
  logic [FPROC_ID_WIDTH-1:0] fproc_id_r;
  logic                      fproc_enable_r;
  logic [DATA_WIDTH-1:0]     result_data_r;
  logic                      result_valid_r;
  logic                      result_timeout_r;
  logic                      busy_r;

`ifdef FPROC_REQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  logic [CNT_W-1:0] wait_cnt_r;
`else
  // Without the abort path the limit has no effect; keep it referenced for configuration sanity.
  if (TIMEOUT_CYCLES >= 2) begin : g_timeout_cfg_ok
  end
`endif

  // Request FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      req_ready_r      <= 1'b0;
      fproc_id_r       <= {FPROC_ID_WIDTH{1'b0}};
      fproc_enable_r   <= 1'b0;
      result_data_r    <= {DATA_WIDTH{1'b0}};
      result_valid_r   <= 1'b0;
      result_timeout_r <= 1'b0;
      busy_r           <= 1'b0;
`ifdef FPROC_REQ_TIMEOUT_EN
      wait_cnt_r       <= CNT_ZERO;
`endif
    end else begin
      fproc_enable_r   <= 1'b0;
      result_valid_r   <= 1'b0;
      result_timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // req_ready is still low on the first cycle out of reset, so nothing is accepted then.
          if (req_valid && req_ready_r) begin
            fproc_id_r     <= req_id;
            fproc_enable_r <= 1'b1;
            req_ready_r    <= 1'b0;
            busy_r         <= 1'b1;
            state_r        <= ST_ISSUE;
          end else begin
            req_ready_r    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_r    <= ST_WAIT;
`ifdef FPROC_REQ_TIMEOUT_EN
          wait_cnt_r <= CNT_ZERO;
`endif
        end
        ST_WAIT: begin
          if (fproc_ready) begin
            result_data_r  <= fproc_data;
            result_valid_r <= 1'b1;
            req_ready_r    <= 1'b1;
            busy_r         <= 1'b0;
            state_r        <= ST_IDLE;
`ifdef FPROC_REQ_TIMEOUT_EN
          end else if (wait_cnt_r == CNT_LAST) begin
            result_data_r    <= {DATA_WIDTH{1'b0}};
            result_valid_r   <= 1'b1;
            result_timeout_r <= 1'b1;
            req_ready_r      <= 1'b1;
            busy_r           <= 1'b0;
            state_r          <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
`else
          end else begin
            state_r <= ST_WAIT;
`endif
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_r;
  assign fproc_id       = fproc_id_r;
  assign fproc_enable   = fproc_enable_r;
  assign result_data    = result_data_r;
  assign result_valid   = result_valid_r;
  assign result_timeout = result_timeout_r;
  assign busy           = busy_r;

endmodule
